// File: rtl/cosim_pkg.sv
// rtl/cosim_pkg.sv - shared types and constants for the cosim watchdog
//
// Purpose: outcome encoding reported to the harness, FSM state encoding,
// and the default counter width used by the watchdog.
// Ports: none (package).
package cosim_pkg;

   localparam int CYCLE_WIDTH_DEF = 64;

   // Outcome codes as seen by the cosim harness on the status bus.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_PASS     = 2'd1,
      ST_TIMEOUT  = 2'd2,
      ST_DUMP_END = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      FSM_RUN    = 2'd0,
      FSM_FINISH = 2'd1,
      FSM_HALT   = 2'd2
   } fsm_e;

endpackage

// File: rtl/cosim_watchdog_if.sv
// rtl/cosim_watchdog_if.sv - finish handshake between watchdog and cosim harness
//
// Purpose: carries the run outcome from the watchdog to the harness.
// Signals:
//   finish_valid  watchdog -> harness  outcome available
//   status        watchdog -> harness  outcome code (RUN/PASS/TIMEOUT/DUMP_END)
//   finish_ready  harness -> watchdog  harness accepts outcome
// Modports: master (watchdog side), slave (harness side).
interface cosim_watchdog_if #(
   parameter int STATUS_WIDTH = 2
);
   logic                    finish_valid;
   logic                    finish_ready;
   logic [STATUS_WIDTH-1:0] status;

   modport master (output finish_valid, output status, input finish_ready);
   modport slave  (input finish_valid, input status, output finish_ready);
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts up on inc, holds at all-ones instead of wrapping.
// Ports:
//   clock  clock
//   reset  synchronous active-high reset (count -> 0)
//   clear  synchronous clear (count -> 0), wins over inc
//   inc    increment request
//   count  current value
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cosim_watchdog.sv
// rtl/cosim_watchdog.sv - end-of-simulation watchdog beside the DUT in the emulation top
//
// Purpose: counts cycles and retired instructions, gates the waveform trace
// window, detects end of run (DUT done, retire-idle timeout, trace-window
// end) and reports the outcome over a valid/ready finish handshake.
// Ports:
//   clock, reset   sole clock, synchronous active-high reset
//   dump_start     first traced cycle (quasi-static)
//   dump_end       cycle that ends the run with DUMP_END, 0 = off (quasi-static)
//   retire_valid   one instruction retired this cycle
//   done_req       DUT reports program completion
//   trace_en       waveform dump enable
//   cycle          cycles elapsed since reset release
//   retired        total retire count
//   fin            finish handshake (finish_valid/status out, finish_ready in)
module cosim_watchdog
   import cosim_pkg::*;
#(
   parameter int CYCLE_WIDTH  = CYCLE_WIDTH_DEF,
   parameter int IDLE_TIMEOUT = 10000,
   parameter int STATUS_WIDTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [CYCLE_WIDTH-1:0] dump_start,
   input  logic [CYCLE_WIDTH-1:0] dump_end,
   input  logic                   retire_valid,
   input  logic                   done_req,
   output logic                   trace_en,
   output logic [CYCLE_WIDTH-1:0] cycle,
   output logic [CYCLE_WIDTH-1:0] retired,
   cosim_watchdog_if.master       fin
);

   // A zero timeout still needs a legal one-bit counter; the check is disabled.
   localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST =
      IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

   fsm_e              state;
   status_e           status_q;
   logic              finish_valid_q;
   logic [IDLE_W-1:0] idle;

   logic              running;
   logic              timeout_ev;
   logic              dump_end_ev;
   logic              any_ev;
   status_e           ev_status;

   assign running     = (state == FSM_RUN);
   assign timeout_ev  = (IDLE_TIMEOUT != 0) && !retire_valid && (idle == IDLE_LAST);
   assign dump_end_ev = (dump_end != '0) && (cycle == dump_end - CYCLE_WIDTH'(1));
   assign any_ev      = done_req || timeout_ev || dump_end_ev;

   always_comb begin
      ev_status = ST_RUN;
      if (done_req)         ev_status = ST_PASS;
      else if (timeout_ev)  ev_status = ST_TIMEOUT;
      else if (dump_end_ev) ev_status = ST_DUMP_END;
   end

   // The cycle count freezes on the triggering edge so it reports the cycle in
   // which the event was seen; the retire of that same cycle is still counted.
   sat_counter #(.WIDTH(CYCLE_WIDTH)) u_cycle (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .inc   (running && !any_ev),
      .count (cycle)
   );

   sat_counter #(.WIDTH(CYCLE_WIDTH)) u_retired (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .inc   (running && retire_valid),
      .count (retired)
   );

   sat_counter #(.WIDTH(IDLE_W)) u_idle (
      .clock (clock),
      .reset (reset),
      .clear (running && retire_valid),
      .inc   (running && !retire_valid),
      .count (idle)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= FSM_RUN;
         status_q       <= ST_RUN;
         finish_valid_q <= 1'b0;
      end else begin
         case (state)
            FSM_RUN: begin
               if (any_ev) begin
                  state          <= FSM_FINISH;
                  status_q       <= ev_status;
                  finish_valid_q <= 1'b1;
               end
            end
            FSM_FINISH: begin
               if (fin.finish_ready) begin
                  state          <= FSM_HALT;
                  finish_valid_q <= 1'b0;
               end
            end
            FSM_HALT: begin
               state <= FSM_HALT;
            end
            default: begin
               state          <= FSM_RUN;
               finish_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign trace_en = running && (cycle >= dump_start) &&
                     ((dump_end == '0) || (cycle < dump_end));

   assign fin.finish_valid = finish_valid_q;
   assign fin.status       = STATUS_WIDTH'(status_q);

endmodule

// File: doc/cosim_watchdog.md
Name: cosim_watchdog

Overview:
- Synthesizable consumer of the testbench clock/reset pair.
- Counts cycles and retired instructions, and gates the waveform trace window.
- Detects end of simulation: DUT done, retire-idle timeout, or trace-window end.
- Reports the outcome to the cosim harness through a valid/ready finish handshake; sits beside the DUT in the emulation top.

Parameters:
CYCLE_WIDTH, 64, width of cycle and retire counters
IDLE_TIMEOUT, 10000, cycles with no retire before TIMEOUT is declared; 0 disables the idle check
STATUS_WIDTH, 2, width of status encoding

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high reset
dump_start  input  CYCLE_WIDTH  first traced cycle; 0 = trace from cycle 0; quasi-static after reset
dump_end  input  CYCLE_WIDTH  cycle at which the run ends with DUMP_END; 0 = disabled; quasi-static
retire_valid  input  1  one instruction retired this cycle
done_req  input  1  DUT signals program completion (pulse or level)
trace_en  output  1  waveform dump enable
cycle  output  CYCLE_WIDTH  cycles elapsed since reset release
retired  output  CYCLE_WIDTH  total retire_valid count
status  output  STATUS_WIDTH  0 RUN, 1 PASS, 2 TIMEOUT, 3 DUMP_END
finish_valid  output  1  outcome available
finish_ready  input  1  harness accepts outcome

Behaviour:
- Reset: applies on a clock edge while reset=1.
  - All outputs 0.
  - FSM in RUN.
  - idle counter 0.
- Reset mid-operation, in any state, returns everything to these values on the next edge.
- Counting in RUN:
  - cycle increments by 1 every edge, so it reads 0 in the first cycle after reset falls.
  - retired increments when retire_valid=1.
  - Both saturate at all-ones; no wrap.
- Idle counter:
  - Cleared on retire_valid=1, else incremented.
  - Width is clog2(IDLE_TIMEOUT+1), saturating.
  - Timeout event when the counter equals IDLE_TIMEOUT-1 and retire_valid=0, i.e. the IDLE_TIMEOUT-th consecutive idle cycle.
- trace_en is combinational from registered state:
  - trace_en = RUN && cycle >= dump_start && (dump_end==0 || cycle < dump_end).
  - dump_start=0 therefore traces from cycle 0.
  - dump_start >= dump_end with dump_end != 0 never traces.
- Dump-end event: dump_end != 0 and cycle == dump_end-1 (last traced cycle).
- FSM states:
  - RUN: status=0, finish_valid=0.
    - The first event moves to FINISH on the next edge with its status latched.
    - Priority on simultaneous events: done_req > timeout > dump_end.
  - FINISH: finish_valid=1.
    - status, cycle and retired are frozen and stable until the handshake.
    - Inputs are ignored.
    - finish_valid && finish_ready -> HALT.
  - HALT: finish_valid=0, status held, counters frozen, trace_en=0.
    - Only reset leaves HALT.
- Latency: event sampled at edge N -> finish_valid=1 from edge N onward (registered, one cycle after the triggering input is asserted).
  - finish_ready may already be high; the handshake then completes at edge N+1.
- The retire in the triggering cycle is counted.
- Counters stop after the edge that enters FINISH.

Decomposition:
- Package cosim_pkg holds:
  - status_e enum (RUN, PASS, TIMEOUT, DUMP_END)
  - fsm state enum (RUN, FINISH, HALT)
  - CYCLE_WIDTH default constant
- Sub-module sat_counter (parameterized width, inc, clear, saturating) instantiated for cycle, retired and idle.

Test Plan:
- Reset 3 cycles, retire every cycle, done_req at cycle 50 -> finish_valid rises next edge; status=1, cycle=50, retired=51; finish_ready=1 -> finish_valid low, HALT, counters frozen.
- IDLE_TIMEOUT=8, no retires after cycle 20 -> status=2 with cycle=28; finish_valid held 5 cycles while finish_ready=0, all outputs stable.
- dump_start=10, dump_end=20, continuous retires -> trace_en high exactly for cycles 10..19; status=3 latched at cycle 19.
- Simultaneous done_req and timeout and dump_end in the same cycle -> status=1 (PASS).
- Reset asserted during FINISH and during RUN at cycle 100 -> next edge all outputs 0, cycle restarts at 0, status RUN.
- dump_start=0, dump_end=0, IDLE_TIMEOUT=0, 1000 idle cycles -> trace_en=1 throughout, no finish; done_req then yields PASS.
